// File: rtl/seg_display_pkg.sv
// Shared 7-segment types and the hex glyph table used by display/status blocks.
// Segment vectors are active high, bit 6 = A ... bit 0 = G.
package seg_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_OFF = 7'h00;

    function automatic seg7_t hex_to_seg7(input logic [3:0] nibble);
        seg7_t seg;
        case (nibble)
            4'h0:    seg = 7'h7E;
            4'h1:    seg = 7'h30;
            4'h2:    seg = 7'h6D;
            4'h3:    seg = 7'h79;
            4'h4:    seg = 7'h33;
            4'h5:    seg = 7'h5B;
            4'h6:    seg = 7'h5F;
            4'h7:    seg = 7'h70;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h7B;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h1F;
            4'hC:    seg = 7'h4E;
            4'hD:    seg = 7'h3D;
            4'hE:    seg = 7'h4F;
            default: seg = 7'h47;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan timebase: slot prescaler, digit index, dead-time/PWM gate, blink phase
// and the frame boundary / registered frame_start pulse.
module seg_scan_timer
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int IDX_W        = 2,
    parameter int DIV_W        = 14,
    parameter int BRIGHT_W     = 4,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic [IDX_W-1:0]    idx,
    output logic                slot_on,
    output logic                boundary,
    output logic                blink_phase,
    output logic                frame_start
);

    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DIV_W-1:0] PRESC_MAX = '1;
    localparam logic [DIV_W-1:0] DEAD_VAL  = DIV_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]    prescaler_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [FC_W-1:0]     frame_cnt_reg;
    logic                blink_phase_reg;
    logic                frame_start_reg;
    logic                wrap;
    logic [BRIGHT_W-1:0] pwm_phase;

    assign wrap        = (prescaler_reg == PRESC_MAX);
    assign boundary    = wrap && (idx_reg == IDX_LAST);
    assign pwm_phase   = prescaler_reg[DIV_W-1 -: BRIGHT_W];
    assign slot_on     = (prescaler_reg >= DEAD_VAL) && (pwm_phase < brightness);
    assign idx         = idx_reg;
    assign blink_phase = blink_phase_reg;
    assign frame_start = frame_start_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_reg   <= '0;
            idx_reg         <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            prescaler_reg   <= prescaler_reg + 1'b1;
            // Registered with the display outputs so it lines up with digit 0 appearing.
            frame_start_reg <= (prescaler_reg == '0) && (idx_reg == '0);
            if (wrap) begin
                idx_reg <= boundary ? '0 : idx_reg + 1'b1;
            end
            if (boundary) begin
                if (frame_cnt_reg == FC_LAST) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// N-digit multiplexed 7-segment driver with double-buffered per-digit controls
// that only switch at frame boundaries, so a frame never mixes old and new data.
module seg_scan_display
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIV_W        = 14,
    parameter int BRIGHT_W     = 4,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   raw_en_in,
    input  logic [7*NUM_DIGITS-1:0] raw_seg_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BANK_W = 15 * NUM_DIGITS;
    // Bank layout {value, raw_en, raw_seg, dp, blank, blink}; reset leaves every digit blanked.
    localparam logic [BANK_W-1:0] BANK_RESET = {{(14*NUM_DIGITS){1'b0}}, {NUM_DIGITS{1'b0}}}
                                             | ({{(14*NUM_DIGITS){1'b0}}, {NUM_DIGITS{1'b1}}} << NUM_DIGITS);

    logic [IDX_W-1:0]        idx;
    logic                    slot_on;
    logic                    boundary;
    logic                    blink_phase;

    logic [BANK_W-1:0]       bank_in;
    logic [BANK_W-1:0]       shadow_reg;
    logic [BANK_W-1:0]       active_reg;
    logic                    pending_reg;

    logic [4*NUM_DIGITS-1:0] act_value;
    logic [NUM_DIGITS-1:0]   act_raw_en;
    logic [7*NUM_DIGITS-1:0] act_raw_seg;
    logic [NUM_DIGITS-1:0]   act_dp;
    logic [NUM_DIGITS-1:0]   act_blank;
    logic [NUM_DIGITS-1:0]   act_blink;

    seg7_t                   digit_seg [NUM_DIGITS];
    seg7_t                   cur_seg;
    logic                    lit;

    logic [6:0]              seg_n_reg;
    logic [6:0]              seg_n_next;
    logic                    dp_n_reg;
    logic                    dp_n_next;
    logic [NUM_DIGITS-1:0]   an_n_reg;
    logic [NUM_DIGITS-1:0]   an_n_next;

    seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .IDX_W       (IDX_W),
        .DIV_W       (DIV_W),
        .BRIGHT_W    (BRIGHT_W),
        .DEAD_CYCLES (DEAD_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .brightness (brightness),
        .idx        (idx),
        .slot_on    (slot_on),
        .boundary   (boundary),
        .blink_phase(blink_phase),
        .frame_start(frame_start)
    );

    assign bank_in = {value_in, raw_en_in, raw_seg_in, dp_in, blank_in, blink_in};
    assign {act_value, act_raw_en, act_raw_seg, act_dp, act_blank, act_blink} = active_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_reg  <= BANK_RESET;
            active_reg  <= BANK_RESET;
            pending_reg <= 1'b0;
        end else begin
            if (load) begin
                shadow_reg <= bank_in;
            end
            if (boundary) begin
                // A load on the boundary cycle bypasses the shadow and goes live now.
                if (load) begin
                    active_reg <= bank_in;
                end else if (pending_reg) begin
                    active_reg <= shadow_reg;
                end
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_seg[gi] = act_raw_en[gi] ? act_raw_seg[7*gi +: 7]
                                              : hex_to_seg7(act_value[4*gi +: 4]);
        assign an_n_next[gi] = ~(lit && (idx == IDX_W'(gi)));
    end

    assign cur_seg    = digit_seg[idx];
    assign lit        = slot_on && !act_blank[idx] && !(act_blink[idx] && blink_phase);
    assign seg_n_next = ~(lit ? cur_seg : SEG_OFF);
    assign dp_n_next  = ~(lit && act_dp[idx]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_n_reg <= '1;
            dp_n_reg  <= 1'b1;
            an_n_reg  <= '1;
        end else begin
            seg_n_reg <= seg_n_next;
            dp_n_reg  <= dp_n_next;
            an_n_reg  <= an_n_next;
        end
    end

    assign seg_n = seg_n_reg;
    assign dp_n  = dp_n_reg;
    assign an_n  = an_n_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Frame-level scoreboard bench for seg_scan_display (4 digits, 16-cycle slots,
// 1 dead cycle, 2-frame blink half-period).
module tb_seg_scan_display;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  raw_en_in;
    logic [27:0] raw_seg_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  blink_in;
    logic [1:0]  brightness;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS  (ND),
        .DIV_W       (4),
        .BRIGHT_W    (2),
        .DEAD_CYCLES (1),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .value_in   (value_in),
        .raw_en_in  (raw_en_in),
        .raw_seg_in (raw_seg_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .blink_in   (blink_in),
        .brightness (brightness),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_start(frame_start)
    );

    // Expected frame: seg_n per digit while lit, dp_n per digit, which digits light,
    // and the exclusive upper bound of lit slot cycles (lit for 1 <= p < hi).
    typedef struct packed {
        logic [7:0]  id;
        logic [27:0] seg;
        logic [3:0]  dp;
        logic [3:0]  lit;
        logic [4:0]  hi;
    } frame_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    function automatic frame_t mk(input int id, input logic [27:0] seg, input logic [3:0] dp,
                                  input logic [3:0] lit, input int hi);
        frame_t f;
        f.id  = 8'(id);
        f.seg = seg;
        f.dp  = dp;
        f.lit = lit;
        f.hi  = 5'(hi);
        return f;
    endfunction

    // ---------------- monitor ----------------
    frame_t     cur;
    bit         in_frame = 0;
    int         off = 0;
    int         s, p;
    bit         slot_bad = 0;
    logic       exp_lit;
    logic [3:0] one_hot;
    logic [3:0] exp_an, bad_an, bad_exp_an;
    logic [6:0] exp_seg, bad_seg, bad_exp_seg;
    logic       exp_dp, bad_dp, bad_exp_dp;
    logic       exp_fs, bad_fs, bad_exp_fs;
    int         bad_off;

    always @(negedge clk) begin
        if (reset) begin
            in_frame = 0;
        end else begin
            if (frame_start) begin
                if (in_frame) begin
                    checks++;
                    if (off != 64) begin
                        errors++;
                        $display("FAIL frame_period frame %0d: got %0d cycles, want 64", cur.id, off);
                    end
                end
                if (exp_q.size() > 0) begin
                    cur      = exp_q.pop_front();
                    in_frame = 1;
                    off      = 0;
                    slot_bad = 0;
                end else begin
                    in_frame = 0;
                end
            end
            if (in_frame) begin
                if (off < 64) begin
                    s       = off / 16;
                    p       = off % 16;
                    one_hot = 4'b0001;
                    exp_lit = cur.lit[s] && (p >= 1) && (p < int'(cur.hi));
                    exp_an  = exp_lit ? ~(one_hot << s) : 4'hF;
                    exp_seg = exp_lit ? cur.seg[7*s +: 7] : 7'h7F;
                    exp_dp  = exp_lit ? cur.dp[s] : 1'b1;
                    exp_fs  = (off == 0);
                    if (!slot_bad && (an_n !== exp_an || seg_n !== exp_seg ||
                                      dp_n !== exp_dp || frame_start !== exp_fs)) begin
                        slot_bad    = 1;
                        bad_off     = off;
                        bad_an      = an_n;
                        bad_seg     = seg_n;
                        bad_dp      = dp_n;
                        bad_fs      = frame_start;
                        bad_exp_an  = exp_an;
                        bad_exp_seg = exp_seg;
                        bad_exp_dp  = exp_dp;
                        bad_exp_fs  = exp_fs;
                    end
                    if (p == 15) begin
                        checks++;
                        if (slot_bad) begin
                            errors++;
                            $display("FAIL slot frame %0d digit %0d cycle %0d: an_n=%b seg_n=%h dp_n=%b fs=%b, want an_n=%b seg_n=%h dp_n=%b fs=%b",
                                     cur.id, s, bad_off, bad_an, bad_seg, bad_dp, bad_fs,
                                     bad_exp_an, bad_exp_seg, bad_exp_dp, bad_exp_fs);
                        end else begin
                            $display("frame %0d digit %0d ok", cur.id, s);
                        end
                        slot_bad = 0;
                    end
                end
                off++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end else begin
            $display("check %s ok (%h)", name, got);
        end
    endtask

    task automatic next_frame(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!frame_start && waited < 200);
        checks++;
        if (!frame_start) begin
            errors++;
            $display("FAIL frame_start_timeout: got none in %0d cycles, want a pulse", waited);
        end
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] re, input logic [27:0] rs,
                           input logic [3:0] dp, input logic [3:0] bl, input logic [3:0] bk);
        value_in   = v;
        raw_en_in  = re;
        raw_seg_in = rs;
        dp_in      = dp;
        blank_in   = bl;
        blink_in   = bk;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    // Hand-decoded seg_n words, digit 3 in the top 7 bits.
    localparam logic [27:0] SEG_D1 = {7'h06, 7'h08, 7'h4F, 7'h01};  // 3 A 1 0
    localparam logic [27:0] SEG_D2 = {7'h06, 7'h08, 7'h4F, 7'h7E};  // digit 0 raw 7'h01
    localparam logic [27:0] SEG_D4 = {7'h0F, 7'h31, 7'h24, 7'h30};  // 7 C 5 E
    localparam logic [27:0] SEG_D5 = {7'h00, 7'h60, 7'h12, 7'h42};  // 8 b 2 d

    initial begin
        int w;
        reset      = 1'b1;
        load       = 1'b0;
        value_in   = '0;
        raw_en_in  = '0;
        raw_seg_in = '0;
        dp_in      = '0;
        blank_in   = '0;
        blink_in   = '0;
        brightness = 2'd3;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_an_n", 32'(an_n), 32'h0000000F);
        chk("reset_seg_n", 32'(seg_n), 32'h0000007F);
        chk("reset_dp_n", 32'(dp_n), 32'h00000001);
        chk("reset_frame_start", 32'(frame_start), 32'h00000000);

        for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 28'h0, 4'hF, 4'h0, 12));
        @(negedge clk);
        reset = 1'b0;
        next_frame(w);
        chk("first_frame_start_latency", 32'(w), 32'd1);
        next_frame(w);
        next_frame(w);
        next_frame(w);                                              // frame 3
        exp_q.push_back(mk(4, SEG_D1, 4'hF, 4'hF, 12));
        repeat (5) @(negedge clk);
        do_load(16'h3A10, 4'b0000, 28'h0, 4'b0000, 4'b0000, 4'b0000);

        next_frame(w);                                              // frame 4
        exp_q.push_back(mk(5, SEG_D2, 4'b1110, 4'hF, 12));
        repeat (5) @(negedge clk);
        do_load(16'h3A10, 4'b0001, 28'h0000001, 4'b0001, 4'b0000, 4'b0000);

        next_frame(w);                                              // frame 5
        exp_q.push_back(mk(6, SEG_D2, 4'b1110, 4'b1011, 12));      // blink phase 1
        repeat (5) @(negedge clk);
        do_load(16'h3A10, 4'b0001, 28'h0000001, 4'b0001, 4'b0000, 4'b0100);

        next_frame(w);
        exp_q.push_back(mk(7, SEG_D2, 4'b1110, 4'b1011, 12));
        next_frame(w);
        exp_q.push_back(mk(8, SEG_D2, 4'b1110, 4'hF, 12));
        next_frame(w);
        exp_q.push_back(mk(9, SEG_D2, 4'b1110, 4'hF, 12));
        next_frame(w);
        exp_q.push_back(mk(10, SEG_D2, 4'b1110, 4'b1011, 12));

        next_frame(w);                                              // frame 10: load at idx 1
        exp_q.push_back(mk(11, SEG_D4, 4'hF, 4'hF, 12));
        repeat (20) @(negedge clk);
        do_load(16'h7C5E, 4'b0000, 28'h0, 4'b0000, 4'b0000, 4'b0000);

        next_frame(w);                                              // frame 11: load on boundary
        exp_q.push_back(mk(12, SEG_D5, 4'hF, 4'b0111, 12));
        repeat (62) @(negedge clk);
        do_load(16'h8B2D, 4'b0000, 28'h0, 4'b0000, 4'b1000, 4'b0000);

        next_frame(w);                                              // frame 12
        exp_q.push_back(mk(13, SEG_D5, 4'hF, 4'b0111, 0));
        next_frame(w);                                              // frame 13
        brightness = 2'd0;
        exp_q.push_back(mk(14, SEG_D5, 4'hF, 4'b0111, 0));
        next_frame(w);                                              // frame 14
        exp_q.push_back(mk(15, SEG_D5, 4'hF, 4'b0111, 12));
        repeat (63) @(negedge clk);
        brightness = 2'd3;

        next_frame(w);                                              // frame 15: reset at idx 2
        repeat (37) @(negedge clk);
        #1;
        chk("lit_before_reset_an_n", 32'(an_n), 32'h0000000B);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_an_n", 32'(an_n), 32'h0000000F);
        chk("async_reset_seg_n", 32'(seg_n), 32'h0000007F);
        chk("async_reset_dp_n", 32'(dp_n), 32'h00000001);
        exp_q.push_back(mk(16, 28'h0, 4'hF, 4'h0, 12));
        exp_q.push_back(mk(17, SEG_D1, 4'hF, 4'hF, 12));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        next_frame(w);
        chk("restart_frame_start_latency", 32'(w), 32'd1);
        repeat (5) @(negedge clk);
        do_load(16'h3A10, 4'b0000, 28'h0, 4'b0000, 4'b0000, 4'b0000);
        next_frame(w);
        next_frame(w);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
